// File: rtl/mini_cpu_pkg.sv
// Shared definitions for the mini CPU multiplier path.
// MUL_RADIX4_EN selects radix-4 Booth recoding (16 iterations) instead of radix-2 (32 iterations).
package mini_cpu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    localparam logic [4:0]  ALU_OP_MUL = 5'b01010;

    localparam int unsigned ITER_R2 = 32;
    localparam int unsigned ITER_R4 = 16;
    localparam int unsigned CNT_W   = 6;

`ifdef MUL_RADIX4_EN
    localparam int unsigned ITER_N   = ITER_R4;
    localparam int unsigned ACC_EXT  = 2;
    localparam int unsigned RECODE_W = 3;
    localparam int unsigned SHIFT_N  = 2;
`else
    localparam int unsigned ITER_N   = ITER_R2;
    localparam int unsigned ACC_EXT  = 1;
    localparam int unsigned RECODE_W = 2;
    localparam int unsigned SHIFT_N  = 1;
`endif

endpackage

// File: rtl/booth_step.sv
// One Booth recode step: picks 0, +-M (or +-2M in radix-4) and adds it to the accumulator.
// MUL_RADIX4_EN selects the radix-4 digit table.
module booth_step
    import mini_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = WIDTH + ACC_EXT
) (
    input  logic [AW-1:0]       acc,
    input  logic [RECODE_W-1:0] recode,
    input  logic [WIDTH-1:0]    mcand,
    output logic [AW-1:0]       acc_next_c
);

    logic [AW-1:0] m_ext;

    assign m_ext = {{(AW-WIDTH){mcand[WIDTH-1]}}, mcand};

`ifdef MUL_RADIX4_EN
    logic [AW-1:0] m_dbl;
    assign m_dbl = m_ext << 1;

    // Radix-4 digit selection over {-2,-1,0,+1,+2}
    always_comb begin
        acc_next_c = acc;
        case (recode)
            3'b001, 3'b010: acc_next_c = acc + m_ext;
            3'b011:         acc_next_c = acc + m_dbl;
            3'b100:         acc_next_c = acc - m_dbl;
            3'b101, 3'b110: acc_next_c = acc - m_ext;
            default:        acc_next_c = acc;
        endcase
    end
`else
    // Radix-2 digit selection over {-1,0,+1}
    always_comb begin
        acc_next_c = acc;
        case (recode)
            2'b01:   acc_next_c = acc + m_ext;
            2'b10:   acc_next_c = acc - m_ext;
            default: acc_next_c = acc;
        endcase
    end
`endif

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential signed Booth multiplier: IDLE -> CALC (N iterations) -> DONE -> IDLE.
// MUL_RADIX4_EN selects radix-4 (17-edge latency) instead of radix-2 (33-edge latency).
module booth_mul_seq
    import mini_cpu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_high,
    output logic [WIDTH-1:0] z_low
);

    localparam int unsigned AW = WIDTH + ACC_EXT;
    localparam int unsigned CW = AW + WIDTH + 1;

    mul_state_e state_q, state_d;

    logic [AW-1:0]       acc_q;
    logic [WIDTH-1:0]    q_q;
    logic                qm1_q;
    logic [WIDTH-1:0]    mcand_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [RECODE_W-1:0] recode;
    logic [AW-1:0]       acc_sum;
    logic signed [CW-1:0] comb_s;
    logic signed [CW-1:0] shifted_s;
    logic [AW-1:0]       acc_sh;
    logic [WIDTH-1:0]    q_sh;
    logic                qm1_sh;
    logic                last_iter;

`ifdef MUL_RADIX4_EN
    assign recode = {q_q[1:0], qm1_q};
`else
    assign recode = {q_q[0], qm1_q};
`endif

    booth_step #(
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_step (
        .acc        (acc_q),
        .recode     (recode),
        .mcand      (mcand_q),
        .acc_next_c (acc_sum)
    );

    // Arithmetic right shift of the combined {acc, Q, q-1} register
    assign comb_s    = {acc_sum, q_q, qm1_q};
    assign shifted_s = comb_s >>> SHIFT_N;
    assign acc_sh    = shifted_s[CW-1:WIDTH+1];
    assign q_sh      = shifted_s[WIDTH:1];
    assign qm1_sh    = shifted_s[0];

    assign last_iter = (cnt_q == CNT_W'(ITER_N - 1));

    // State register; clear overrides every transition
    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_CALC;
            ST_CALC: if (last_iter) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath, product registers and registered handshake flags
    always_ff @(posedge Clock) begin
        if (clear) begin
            acc_q   <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            mcand_q <= '0;
            cnt_q   <= '0;
            z_high  <= '0;
            z_low   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            busy <= (state_d != ST_IDLE);
            done <= (state_d == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mcand_q <= multiplicand;
                        q_q     <= multiplier;
                        qm1_q   <= 1'b0;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_sh;
                    q_q   <= q_sh;
                    qm1_q <= qm1_sh;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        z_high <= acc_sh[WIDTH-1:0];
                        z_low  <= q_sh;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq against a plain 64-bit signed multiply model.
module tb_booth_mul_seq;

`ifdef MUL_RADIX4_EN
    localparam int N = 16;
`else
    localparam int N = 32;
`endif
    localparam int LAT = N + 1;

    logic        Clock = 1'b0;
    logic        clear = 1'b1;
    logic        start = 1'b0;
    logic [31:0] multiplicand = '0;
    logic [31:0] multiplier = '0;
    logic        busy;
    logic        done;
    logic [31:0] z_high;
    logic [31:0] z_low;

    int checks = 0;
    int errors = 0;

    booth_mul_seq #(.WIDTH(32)) dut (
        .Clock        (Clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .z_high       (z_high),
        .z_low        (z_low)
    );

    always #5 Clock = ~Clock;

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint pa;
        longint pb;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        return 64'(pa * pb);
    endfunction

    // Issue one multiply, scramble operands after capture, wait for done (bounded)
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b,
                           output int lat, output logic timeout);
        @(negedge Clock);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        lat = 1;
        while (done !== 1'b1 && lat < 200) begin
            @(posedge Clock);
            @(negedge Clock);
            lat++;
        end
        timeout = (done !== 1'b1);
    endtask

    task automatic test_reset;
        @(negedge Clock);
        clear = 1'b1;
        start = 1'b1;
        multiplicand = 32'd7;
        multiplier   = 32'd9;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_flags: busy/done=%b required 00", {busy, done});
        end
        checks++;
        if ({z_high, z_low} !== 64'd0) begin
            errors++;
            $display("FAIL reset_z: got %h required 0", {z_high, z_low});
        end
        clear = 1'b0;
        start = 1'b0;
        @(posedge Clock);
        @(negedge Clock);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_directed;
        logic [31:0] da [3];
        logic [31:0] db [3];
        int lat;
        logic to;
        da[0] = 32'd12;         db[0] = 32'hFFFFFFFB;
        da[1] = 32'h80000000;   db[1] = 32'h80000000;
        da[2] = 32'h7FFFFFFF;   db[2] = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            run_mul(da[i], db[i], lat, to);
            checks++;
            if (to || lat != LAT) begin
                errors++;
                $display("FAIL dir%0d_latency: got %0d edges (timeout=%b) required %0d", i, lat, to, LAT);
            end
            checks++;
            if ({z_high, z_low} !== ref_mul(da[i], db[i])) begin
                errors++;
                $display("FAIL dir%0d_product: got %h required %h", i, {z_high, z_low}, ref_mul(da[i], db[i]));
            end
            @(posedge Clock);
            @(negedge Clock);
            checks++;
            if ({busy, done} !== 2'b00) begin
                errors++;
                $display("FAIL dir%0d_pulse: busy/done=%b required 00", i, {busy, done});
            end
            checks++;
            if ({z_high, z_low} !== ref_mul(da[i], db[i])) begin
                errors++;
                $display("FAIL dir%0d_hold: got %h required %h", i, {z_high, z_low}, ref_mul(da[i], db[i]));
            end
        end
        checks++;
        if ({z_high, z_low} !== 64'hFFFFFFFF_80000001) begin
            errors++;
            $display("FAIL dir_const: got %h required FFFFFFFF80000001", {z_high, z_low});
        end
    endtask

    task automatic test_restart_ignored;
        logic [31:0] a;
        logic [31:0] b;
        int t;
        int first;
        int pulses;
        a = 32'h7FFFFFFF;
        b = 32'hFFFFFFFF;
        @(negedge Clock);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        start = 1'b0;
        t = 1;
        first = -1;
        pulses = 0;
        while (t < LAT + 10) begin
            if (t == 6) begin
                start        = 1'b1;
                multiplicand = 32'd3;
                multiplier   = 32'd5;
            end else if (t == 7) begin
                start = 1'b0;
            end
            @(posedge Clock);
            @(negedge Clock);
            t++;
            if (done === 1'b1) begin
                pulses++;
                if (first < 0) first = t;
                if (t == LAT) begin
                    checks++;
                    if ({z_high, z_low} !== ref_mul(a, b)) begin
                        errors++;
                        $display("FAIL restart_product: got %h required %h", {z_high, z_low}, ref_mul(a, b));
                    end
                end
            end
        end
        checks++;
        if (first != LAT || pulses != 1) begin
            errors++;
            $display("FAIL restart_done: first at %0d, %0d pulses; required at %0d, 1 pulse", first, pulses, LAT);
        end
    endtask

    task automatic test_clear_abort;
        int pulses;
        @(negedge Clock);
        multiplicand = 32'd1000;
        multiplier   = 32'd77;
        start        = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        start = 1'b0;
        repeat (10) begin
            @(posedge Clock);
            @(negedge Clock);
        end
        clear = 1'b1;
        @(posedge Clock);
        @(negedge Clock);
        clear = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL clear_flags: busy=%b done=%b required 0 0", busy, done);
        end
        checks++;
        if ({z_high, z_low} !== 64'd0) begin
            errors++;
            $display("FAIL clear_z: got %h required 0", {z_high, z_low});
        end
        pulses = 0;
        repeat (40) begin
            @(posedge Clock);
            @(negedge Clock);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL clear_no_done: %0d busy/done cycles required 0", pulses);
        end
    endtask

    task automatic test_back_to_back;
        int t;
        int first;
        int second;
        logic [63:0] r1;
        @(negedge Clock);
        multiplicand = 32'd3;
        multiplier   = 32'd4;
        start        = 1'b1;
        t = 0;
        first = -1;
        second = -1;
        r1 = '0;
        while (second < 0 && t < 200) begin
            @(posedge Clock);
            @(negedge Clock);
            t++;
            if (done === 1'b1) begin
                if (first < 0) begin
                    first = t;
                    r1 = {z_high, z_low};
                    multiplicand = 32'd0;
                    multiplier   = 32'hFFFFFFFF;
                end else begin
                    second = t;
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (first < 0 || second < 0 || second - first != N + 2) begin
            errors++;
            $display("FAIL b2b_gap: first=%0d second=%0d required gap %0d", first, second, N + 2);
        end
        checks++;
        if (r1 !== 64'd12) begin
            errors++;
            $display("FAIL b2b_first: got %h required 12", r1);
        end
        checks++;
        if ({z_high, z_low} !== 64'd0) begin
            errors++;
            $display("FAIL b2b_second: got %h required 0", {z_high, z_low});
        end
        repeat (3) begin
            @(posedge Clock);
            @(negedge Clock);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%b required 0", busy);
        end
    endtask

    task automatic test_random;
        logic [31:0] a;
        logic [31:0] b;
        int lat;
        logic to;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i == 0) a = 32'h80000000;
            if (i == 1) b = 32'h80000000;
            if (i == 2) a = 32'h00000000;
            if (i == 3) b = 32'hFFFFFFFF;
            run_mul(a, b, lat, to);
            checks++;
            if (to || lat != LAT || {z_high, z_low} !== ref_mul(a, b)) begin
                errors++;
                $display("FAIL rand%0d: %h*%h got %h lat %0d required %h lat %0d",
                         i, a, b, {z_high, z_low}, lat, ref_mul(a, b), LAT);
            end
        end
    endtask

    initial begin
        repeat (2) @(posedge Clock);
        test_reset();
        test_directed();
        test_restart_ignored();
        test_clear_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
